ex_div: RTL and testbench

- EX-stage consumer of the ID/EX register outputs: op1, op2, inst, inst_addr, reg_wen, rd_addr.
- Executes the RV32M DIV, DIVU, REM and REMU instructions with a multi-cycle radix-2 restoring divider.
- Requests a pipeline hold from ctrl while it computes.
- Emits a single-cycle result toward the EX writeback mux.

---
 rtl/ex_div_if.sv | 29 ++
 rtl/ex_div.sv | 184 ++++++++++++++++++
 tb/tb_ex_div.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_if.sv
// Operand, control and writeback signals between id_ex/ctrl and the ex_div divider.
// Signal suffixes are named from the divider's point of view.
interface ex_div_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [31:0]     inst_i;
    logic [31:0]     inst_addr_i;
    logic            reg_wen_i;
    logic [4:0]      rd_addr_i;
    logic            flush_i;
    logic            hold_req_o;
    logic            busy_o;
    logic [XLEN-1:0] result_o;
    logic            result_valid_o;
    logic            reg_wen_o;
    logic [4:0]      rd_addr_o;

    modport master (
        output op1_i, op2_i, inst_i, inst_addr_i, reg_wen_i, rd_addr_i, flush_i,
        input  hold_req_o, busy_o, result_o, result_valid_o, reg_wen_o, rd_addr_o
    );

    modport slave (
        input  op1_i, op2_i, inst_i, inst_addr_i, reg_wen_i, rd_addr_i, flush_i,
        output hold_req_o, busy_o, result_o, result_valid_o, reg_wen_o, rd_addr_o
    );
endinterface

// File: rtl/ex_div.sv
// RV32M DIV/DIVU/REM/REMU execute unit: radix-2 restoring divider, one quotient bit per cycle.
// Define DIV_EARLY_OUT_EN to finish in one cycle whenever |dividend| < |divisor|.
module ex_div #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic    clk,
    input  logic    rst,
    ex_div_if.slave divIf
);
    localparam logic [6:0]       OPCODE_OP     = 7'b0110011;
    localparam logic [6:0]       FUNCT7_MULDIV = 7'b0000001;
    localparam logic [CNT_W-1:0] LAST_ITER     = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic             remSel_q;
    logic             qSign_q;
    logic             rSign_q;
    logic             regWen_q;
    logic [4:0]       rdAddr_q;
    logic [XLEN-1:0]  divisor_q;
    logic [XLEN-1:0]  quot_q;
    logic [XLEN-1:0]  rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  result_q;
    logic             resultValid_q;
    logic             regWenOut_q;

    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [31:0]      inst;
    logic             isDivInst;
    logic             opRem;
    logic             opUnsigned;
    logic             start;
    logic [XLEN-1:0]  mag1;
    logic [XLEN-1:0]  mag2;
    logic             divZero;
    logic             overflow;
    logic             earlyOut;
    logic             fastPath;
    logic [XLEN-1:0]  fastResult;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    trial;
    logic [XLEN-1:0]  rem_d;
    logic [XLEN-1:0]  quot_d;
    logic [XLEN-1:0]  calcResult;
    logic             unusedBits;

    assign op1  = divIf.op1_i;
    assign op2  = divIf.op2_i;
    assign inst = divIf.inst_i;

    // funct3 bit 1 selects remainder, bit 0 selects unsigned
    assign isDivInst  = (inst[6:0] == OPCODE_OP) && (inst[31:25] == FUNCT7_MULDIV) && inst[14];
    assign opRem      = inst[13];
    assign opUnsigned = inst[12];
    assign start      = (state_q == IDLE) && isDivInst && !divIf.flush_i;

    assign unusedBits = ^{divIf.inst_addr_i, inst[24:15], inst[11:7]};

    assign mag1 = (!opUnsigned && op1[XLEN-1]) ? (~op1 + 1'b1) : op1;
    assign mag2 = (!opUnsigned && op2[XLEN-1]) ? (~op2 + 1'b1) : op2;

    assign divZero  = (op2 == '0);
    assign overflow = !opUnsigned && (op1 == INT_MIN) && (op2 == '1);
`ifdef DIV_EARLY_OUT_EN
    assign earlyOut = !divZero && (mag1 < mag2);
`else
    assign earlyOut = 1'b0;
`endif
    assign fastPath = divZero || overflow || earlyOut;

    // Every fast-path case already knows its final, sign-correct answer at start
    always_comb begin
        fastResult = '0;
        if (divZero) begin
            fastResult = opRem ? op1 : '1;
        end else if (overflow) begin
            fastResult = opRem ? '0 : INT_MIN;
        end else begin
            fastResult = opRem ? op1 : '0;
        end
    end

    // One restoring step; the final step's result is sign-corrected on the way into DONE
    always_comb begin
        shifted = {rem_q, quot_q[XLEN-1]};
        trial   = shifted - {1'b0, divisor_q};
        rem_d   = shifted[XLEN-1:0];
        quot_d  = {quot_q[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_d     = trial[XLEN-1:0];
            quot_d[0] = 1'b1;
        end
        if (remSel_q) begin
            calcResult = rSign_q ? (~rem_d + 1'b1) : rem_d;
        end else begin
            calcResult = qSign_q ? (~quot_d + 1'b1) : quot_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            remSel_q      <= 1'b0;
            qSign_q       <= 1'b0;
            rSign_q       <= 1'b0;
            regWen_q      <= 1'b0;
            rdAddr_q      <= '0;
            divisor_q     <= '0;
            quot_q        <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
            result_q      <= '0;
            resultValid_q <= 1'b0;
            regWenOut_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resultValid_q <= 1'b0;
                    regWenOut_q   <= 1'b0;
                    if (start) begin
                        remSel_q  <= opRem;
                        regWen_q  <= divIf.reg_wen_i;
                        rdAddr_q  <= divIf.rd_addr_i;
                        qSign_q   <= !opRem && !opUnsigned && (op1[XLEN-1] ^ op2[XLEN-1]);
                        rSign_q   <= opRem && !opUnsigned && op1[XLEN-1];
                        quot_q    <= mag1;
                        divisor_q <= mag2;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        if (fastPath) begin
                            result_q      <= fastResult;
                            resultValid_q <= 1'b1;
                            regWenOut_q   <= divIf.reg_wen_i;
                            state_q       <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (divIf.flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        cnt_q  <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_ITER) begin
                            result_q      <= calcResult;
                            resultValid_q <= 1'b1;
                            regWenOut_q   <= regWen_q;
                            state_q       <= DONE;
                        end
                    end
                end
                DONE: begin
                    resultValid_q <= 1'b0;
                    regWenOut_q   <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // hold must rise in the start cycle itself so ctrl freezes the upstream stages in time
    assign divIf.hold_req_o     = start || (state_q == CALC);
    assign divIf.busy_o         = (state_q != IDLE);
    assign divIf.result_o       = result_q;
    assign divIf.result_valid_o = resultValid_q && !divIf.flush_i;
    assign divIf.reg_wen_o      = regWenOut_q && !divIf.flush_i;
    assign divIf.rd_addr_o      = rdAddr_q;
endmodule

// File: tb/tb_ex_div.sv
// Randomized and directed bench for ex_div, checked against an arithmetic reference model.
module tb_ex_div;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    ex_div_if #(.XLEN(32)) divIf ();

    ex_div #(.XLEN(32), .CNT_W(6)) dut (
        .clk  (clk),
        .rst  (rst),
        .divIf(divIf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference: RISC-V division semantics, including the divide-by-zero and overflow rules
    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
        case (f3[1:0])
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] ma;
        logic [31:0] mb;
`endif
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        ma = (!f3[0] && a[31]) ? (32'd0 - a) : a;
        mb = (!f3[0] && b[31]) ? (32'd0 - b) : b;
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] divInst(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Issues one divide at posedge+1, holds it on inst_i until the strobe, then checks the result cycle
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic wen);
        int          lat;
        int          holdCycles;
        int          expLat;
        logic [31:0] expRes;
        string       id;
        expRes = refResult(f3, a, b);
        expLat = refLatency(f3, a, b);
        id = $sformatf("f3=%0d a=%08h b=%08h", f3, a, b);
        divIf.inst_i      = divInst(f3, rd);
        divIf.op1_i       = a;
        divIf.op2_i       = b;
        divIf.rd_addr_i   = rd;
        divIf.reg_wen_i   = wen;
        divIf.inst_addr_i = $urandom;
        #1;
        checkOutput({"hold_start ", id}, {31'd0, divIf.hold_req_o}, 32'd1);
        holdCycles = 1;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (divIf.result_valid_o) break;
            if (divIf.hold_req_o) holdCycles++;
        end
        checkOutput({"latency ", id}, 32'(lat), 32'(expLat));
        checkOutput({"hold_cycles ", id}, 32'(holdCycles), 32'(expLat));
        checkOutput({"result ", id}, divIf.result_o, expRes);
        checkOutput({"rd_addr ", id}, {27'd0, divIf.rd_addr_o}, {27'd0, rd});
        checkOutput({"reg_wen ", id}, {31'd0, divIf.reg_wen_o}, {31'd0, wen});
        checkOutput({"hold_done ", id}, {31'd0, divIf.hold_req_o}, 32'd0);
        divIf.inst_i = NOP_INST;
        @(posedge clk);
        #1;
        checkOutput({"valid_after ", id}, {31'd0, divIf.result_valid_o}, 32'd0);
        checkOutput({"busy_after ", id}, {31'd0, divIf.busy_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        int          strobes;
        int          holds;

        $display("[TB] ex_div bench start");
        rst               = 1'b1;
        divIf.inst_i      = NOP_INST;
        divIf.op1_i       = 32'd0;
        divIf.op2_i       = 32'd0;
        divIf.inst_addr_i = 32'd0;
        divIf.reg_wen_i   = 1'b0;
        divIf.rd_addr_i   = 5'd0;
        divIf.flush_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("reset hold", {31'd0, divIf.hold_req_o}, 32'd0);
        checkOutput("reset busy", {31'd0, divIf.busy_o}, 32'd0);
        checkOutput("reset valid", {31'd0, divIf.result_valid_o}, 32'd0);
        checkOutput("reset reg_wen", {31'd0, divIf.reg_wen_o}, 32'd0);
        checkOutput("reset rd_addr", {27'd0, divIf.rd_addr_o}, 32'd0);
        checkOutput("reset result", divIf.result_o, 32'd0);
        @(posedge clk);
        #1;

        // Directed cases
        applyStimulus(3'b101, 32'd100, 32'd7, 5'd5, 1'b1);
        applyStimulus(3'b111, 32'd100, 32'd7, 5'd5, 1'b1);
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);
        applyStimulus(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd8, 1'b1);
        applyStimulus(3'b110, 32'd7, 32'hFFFF_FFFE, 5'd9, 1'b0);
        applyStimulus(3'b100, 32'd5, 32'd0, 5'd10, 1'b1);
        applyStimulus(3'b111, 32'd5, 32'd0, 5'd11, 1'b1);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b1);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1);
        applyStimulus(3'b101, 32'd3, 32'd10, 5'd14, 1'b1);
        applyStimulus(3'b111, 32'd3, 32'd10, 5'd15, 1'b1);
        applyStimulus(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1'b1);

        // Flush in CALC cycle 10, then a fresh divide
        divIf.inst_i    = divInst(3'b101, 5'd20);
        divIf.op1_i     = 32'd1000;
        divIf.op2_i     = 32'd3;
        divIf.rd_addr_i = 5'd20;
        divIf.reg_wen_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        divIf.flush_i = 1'b1;
        #1;
        checkOutput("flush_calc valid", {31'd0, divIf.result_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        divIf.flush_i = 1'b0;
        divIf.inst_i  = NOP_INST;
        #1;
        checkOutput("flush_calc busy", {31'd0, divIf.busy_o}, 32'd0);
        checkOutput("flush_calc hold", {31'd0, divIf.hold_req_o}, 32'd0);
        strobes = 0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (divIf.result_valid_o) strobes++;
        end
        checkOutput("flush_calc strobes", 32'(strobes), 32'd0);
        applyStimulus(3'b101, 32'd9, 32'd3, 5'd21, 1'b1);

        // Flush in the DONE cycle of a fast-path divide
        divIf.inst_i    = divInst(3'b100, 5'd22);
        divIf.op1_i     = 32'd5;
        divIf.op2_i     = 32'd0;
        divIf.rd_addr_i = 5'd22;
        divIf.reg_wen_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_done pre valid", {31'd0, divIf.result_valid_o}, 32'd1);
        divIf.inst_i  = NOP_INST;
        divIf.flush_i = 1'b1;
        #1;
        checkOutput("flush_done valid", {31'd0, divIf.result_valid_o}, 32'd0);
        checkOutput("flush_done reg_wen", {31'd0, divIf.reg_wen_o}, 32'd0);
        @(posedge clk);
        #1;
        divIf.flush_i = 1'b0;
        checkOutput("flush_done busy", {31'd0, divIf.busy_o}, 32'd0);

        // Flush while idle with a divide present: nothing starts
        divIf.inst_i  = divInst(3'b101, 5'd23);
        divIf.op2_i   = 32'd3;
        divIf.flush_i = 1'b1;
        #1;
        checkOutput("flush_idle hold", {31'd0, divIf.hold_req_o}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("flush_idle busy", {31'd0, divIf.busy_o}, 32'd0);
        divIf.flush_i = 1'b0;
        divIf.inst_i  = NOP_INST;
        @(posedge clk);
        #1;

        // Reset in the middle of CALC
        divIf.inst_i    = divInst(3'b101, 5'd24);
        divIf.op1_i     = 32'd1000;
        divIf.op2_i     = 32'd3;
        divIf.rd_addr_i = 5'd24;
        divIf.reg_wen_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst          = 1'b1;
        divIf.inst_i = NOP_INST;
        @(posedge clk);
        #1;
        checkOutput("rst_mid busy", {31'd0, divIf.busy_o}, 32'd0);
        checkOutput("rst_mid valid", {31'd0, divIf.result_valid_o}, 32'd0);
        checkOutput("rst_mid reg_wen", {31'd0, divIf.reg_wen_o}, 32'd0);
        checkOutput("rst_mid rd_addr", {27'd0, divIf.rd_addr_o}, 32'd0);
        checkOutput("rst_mid result", divIf.result_o, 32'd0);
        checkOutput("rst_mid hold", {31'd0, divIf.hold_req_o}, 32'd0);
        rst = 1'b0;

        // ADD and MUL are not divides
        for (int k = 0; k < 2; k++) begin
            divIf.inst_i = (k == 0) ? {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}
                                    : {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
            divIf.op1_i  = 32'd50;
            divIf.op2_i  = 32'd5;
            strobes = 0;
            holds   = 0;
            repeat (35) begin
                #1;
                if (divIf.hold_req_o) holds++;
                @(posedge clk);
                #1;
                if (divIf.result_valid_o || divIf.busy_o) strobes++;
            end
            checkOutput($sformatf("nondiv%0d hold", k), 32'(holds), 32'd0);
            checkOutput($sformatf("nondiv%0d activity", k), 32'(strobes), 32'd0);
        end
        divIf.inst_i = NOP_INST;
        @(posedge clk);
        #1;

        // Randomized operations with biased corner cases
        for (int n = 0; n < 60; n++) begin
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 9))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 20); b = $urandom_range(21, 60); end
                3: begin a = 32'd0 - $urandom_range(1, 20); b = $urandom_range(21, 60); end
                default: begin
                    a = $urandom >> $urandom_range(0, 31);
                    b = $urandom >> $urandom_range(0, 31);
                    if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
                end
            endcase
            applyStimulus(f3, a, b, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
